// File: rtl/cpu_host_loader.sv
// Host-side loader for the A-RISC cpu: parses a byte frame into IRAM/DRAM writes,
// starts the CPU, waits for idle (optional watchdog) and streams a DRAM window back out.
module cpu_host_loader #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        iram_we,
  output logic [7:0]  iram_waddr,
  output logic [15:0] iram_wdata,
  output logic        hd_we,
  output logic [7:0]  hd_addr,
  output logic [7:0]  hd_din,
  input  logic [7:0]  hd_dout,
  output logic        cpu_start,
  input  logic        cpu_idle,
  output logic        err
);

  typedef enum logic [3:0] {
    S_NI, S_ILO, S_IHI, S_ND, S_DDAT, S_NR, S_RB,
    S_START, S_RUN, S_RD, S_WAIT, S_SEND, S_HALT
  } state_t;

  localparam logic [31:0] WD_LAST = TIMEOUT - 1;

  state_t      state_q, state_d;
  logic [7:0]  ni_q, ni_d, nd_q, nd_d, nr_q, nr_d, rb_q, rb_d;
  logic [7:0]  cnt_q, cnt_d, lo_q, lo_d;
  logic [31:0] wd_q, wd_d;
  logic        s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        iram_we_q, iram_we_d;
  logic [7:0]  iram_waddr_q, iram_waddr_d;
  logic [15:0] iram_wdata_q, iram_wdata_d;
  logic        hd_we_q, hd_we_d;
  logic [7:0]  hd_addr_q, hd_addr_d, hd_din_q, hd_din_d;
  logic        cpu_start_q, cpu_start_d, err_q, err_d;
  logic        hs;

  assign hs = s_valid && s_ready_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    ni_d         = ni_q;
    nd_d         = nd_q;
    nr_d         = nr_q;
    rb_d         = rb_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    wd_d         = wd_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    iram_we_d    = 1'b0;
    iram_waddr_d = iram_waddr_q;
    iram_wdata_d = iram_wdata_q;
    hd_we_d      = 1'b0;
    hd_addr_d    = hd_addr_q;
    hd_din_d     = hd_din_q;
    cpu_start_d  = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      S_NI: if (hs) begin
        ni_d    = s_data;
        cnt_d   = 8'd0;
        state_d = (s_data == 8'd0) ? S_ND : S_ILO;
      end
      S_ILO: if (hs) begin
        lo_d    = s_data;
        state_d = S_IHI;
      end
      S_IHI: if (hs) begin
        iram_we_d    = 1'b1;
        iram_waddr_d = cnt_q;
        iram_wdata_d = {s_data, lo_q};
        cnt_d        = cnt_q + 8'd1;
        state_d      = (cnt_q == ni_q - 8'd1) ? S_ND : S_ILO;
      end
      S_ND: if (hs) begin
        nd_d    = s_data;
        cnt_d   = 8'd0;
        state_d = (s_data == 8'd0) ? S_NR : S_DDAT;
      end
      S_DDAT: if (hs) begin
        hd_we_d   = 1'b1;
        hd_addr_d = cnt_q;
        hd_din_d  = s_data;
        cnt_d     = cnt_q + 8'd1;
        state_d   = (cnt_q == nd_q - 8'd1) ? S_NR : S_DDAT;
      end
      S_NR: if (hs) begin
        nr_d    = s_data;
        state_d = S_RB;
      end
      S_RB: if (hs) begin
        rb_d        = s_data;
        cpu_start_d = 1'b1;
        state_d     = S_START;
      end
      // The CPU still reports idle during the start cycle; only S_RUN looks at it.
      S_START: begin
        wd_d    = 32'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cpu_idle) begin
          cnt_d = 8'd0;
          if (nr_q == 8'd0) begin
            state_d = S_NI;
          end else begin
            hd_addr_d = rb_q;
            state_d   = S_RD;
          end
        end else begin
          wd_d = wd_q + 32'd1;
          if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      // hd_addr is held through S_RD; the RAM returns the byte during S_WAIT.
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        m_data_d  = hd_dout;
        m_valid_d = 1'b1;
        state_d   = S_SEND;
      end
      S_SEND: if (m_ready) begin
        m_valid_d = 1'b0;
        if (cnt_q == nr_q - 8'd1) begin
          state_d = S_NI;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          hd_addr_d = rb_q + cnt_q + 8'd1;
          state_d   = S_RD;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_NI;
    endcase

    s_ready_d = state_d inside {S_NI, S_ILO, S_IHI, S_ND, S_DDAT, S_NR, S_RB};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_NI;
      ni_q         <= '0;
      nd_q         <= '0;
      nr_q         <= '0;
      rb_q         <= '0;
      cnt_q        <= '0;
      lo_q         <= '0;
      wd_q         <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      iram_we_q    <= 1'b0;
      iram_waddr_q <= '0;
      iram_wdata_q <= '0;
      hd_we_q      <= 1'b0;
      hd_addr_q    <= '0;
      hd_din_q     <= '0;
      cpu_start_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ni_q         <= ni_d;
      nd_q         <= nd_d;
      nr_q         <= nr_d;
      rb_q         <= rb_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      wd_q         <= wd_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      iram_we_q    <= iram_we_d;
      iram_waddr_q <= iram_waddr_d;
      iram_wdata_q <= iram_wdata_d;
      hd_we_q      <= hd_we_d;
      hd_addr_q    <= hd_addr_d;
      hd_din_q     <= hd_din_d;
      cpu_start_q  <= cpu_start_d;
      err_q        <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign iram_we    = iram_we_q;
  assign iram_waddr = iram_waddr_q;
  assign iram_wdata = iram_wdata_q;
  assign hd_we      = hd_we_q;
  assign hd_addr    = hd_addr_q;
  assign hd_din     = hd_din_q;
  assign cpu_start  = cpu_start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed bench for cpu_host_loader: byte-vector table plus readback, gap, reset and watchdog sequences.
module tb_cpu_host_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        iram_we;
  logic [7:0]  iram_waddr;
  logic [15:0] iram_wdata;
  logic        hd_we;
  logic [7:0]  hd_addr;
  logic [7:0]  hd_din;
  logic [7:0]  hd_dout;
  logic        cpu_start;
  logic        cpu_idle;
  logic        err;

  int vectors = 0;
  int misses  = 0;

  cpu_host_loader #(.TIMEOUT(50)) dut (
    .clk(clk), .rstn(rstn),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .iram_we(iram_we), .iram_waddr(iram_waddr), .iram_wdata(iram_wdata),
    .hd_we(hd_we), .hd_addr(hd_addr), .hd_din(hd_din), .hd_dout(hd_dout),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle), .err(err)
  );

  always #5 clk = ~clk;

  // Data RAM with synchronous read on the host port.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (hd_we) mem[hd_addr] <= hd_din;
    hd_dout <= mem[hd_addr];
  end

  // CPU model: drops idle on start, raises it 10 cycles later unless hung.
  logic hang = 1'b0;
  int   busy;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_idle <= 1'b1;
      busy     <= 0;
    end else if (cpu_start) begin
      cpu_idle <= 1'b0;
      busy     <= 10;
    end else if (busy > 0 && !hang) begin
      busy <= busy - 1;
      if (busy == 1) cpu_idle <= 1'b1;
    end
  end

  typedef struct packed { logic [7:0] a; logic [15:0] d; } iw_t;
  iw_t  iram_log[$];
  int   hd_cnt = 0, start_cnt = 0, mv_rise = 0;
  logic mv_prev = 1'b0;
  always @(negedge clk) begin
    if (iram_we) iram_log.push_back({iram_waddr, iram_wdata});
    if (hd_we) hd_cnt++;
    if (cpu_start) start_cnt++;
    if (m_valid && !mv_prev) mv_rise++;
    mv_prev = m_valid;
  end

  typedef struct {
    logic [7:0]  din;
    logic        iwe;
    logic [7:0]  iaddr;
    logic [15:0] idata;
    logic        hwe;
    logic [7:0]  haddr;
    logic [7:0]  hdin;
    logic        start;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_wait", {63'b0, s_ready}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'b0, s_ready}, 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {s_ready, m_valid, m_data, iram_we, iram_waddr, iram_wdata,
                 hd_we, hd_addr, hd_din, cpu_start, err}, 64'd0);
  endtask

  vec_t tbl[11];
  logic [7:0] rb_exp[3];

  initial begin
    int n;
    int s0, h0, m0;
    logic seen_ready;

    tbl = '{
      '{8'h02, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'h18, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'h35, 1'b1, 8'h00, 16'h3518, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'h01, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'h00, 1'b1, 8'h01, 16'h0001, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'h03, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'hAA, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h00, 8'hAA, 1'b0},
      '{8'hBB, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h01, 8'hBB, 1'b0},
      '{8'hCC, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h02, 8'hCC, 1'b0},
      '{8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0},
      '{8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b1}
    };
    rb_exp = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Power-on reset.
    #12;
    check_all_zero("reset_values");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("s_ready_before_clock", {63'b0, s_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("s_ready_after_reset", {63'b0, s_ready}, 64'd1);

    // Program + data load, empty readback: strobes checked the cycle after each handshake.
    for (int i = 0; i < 11; i++) begin
      send_byte(tbl[i].din, 1'b0);
      check($sformatf("v%0d_strobes", i), {iram_we, hd_we, cpu_start},
            {tbl[i].iwe, tbl[i].hwe, tbl[i].start});
      if (tbl[i].iwe)
        check($sformatf("v%0d_iram", i), {iram_waddr, iram_wdata}, {tbl[i].iaddr, tbl[i].idata});
      if (tbl[i].hwe)
        check($sformatf("v%0d_dram", i), {hd_addr, hd_din}, {tbl[i].haddr, tbl[i].hdin});
    end
    wait_ready("load_back_to_ni");
    check("load_start_count", start_cnt, 1);
    check("load_no_m_valid", mv_rise, 0);
    check("load_hd_we_count", hd_cnt, 3);
    check("load_iram_count", iram_log.size(), 2);
    check("load_dram_contents", {mem[0], mem[1], mem[2]}, 24'hAABBCC);

    // Readback across the 255->0 wrap, with backpressure on the second byte.
    mem[8'hFE] = 8'h11;
    mem[8'hFF] = 8'h22;
    mem[8'h00] = 8'h33;
    m0 = mv_rise;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hFE, 1'b0);
    check("rb_start_pulse", {63'b0, cpu_start}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rb%0d_valid", k), {63'b0, m_valid}, 64'd1);
      check($sformatf("rb%0d_data", k), m_data, rb_exp[k]);
      if (k == 1) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check($sformatf("rb1_hold%0d", c), {m_valid, m_data}, {1'b1, rb_exp[1]});
        end
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      check($sformatf("rb%0d_drop", k), {63'b0, m_valid}, 64'd0);
    end
    wait_ready("rb_back_to_ni");
    check("rb_byte_count", mv_rise - m0, 3);

    // Same 2-word program, s_valid toggling every other cycle.
    iram_log.delete();
    send_byte(8'h02, 1'b1);
    send_byte(8'h18, 1'b1);
    send_byte(8'h35, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_ready("gap_back_to_ni");
    check("gap_iram_count", iram_log.size(), 2);
    if (iram_log.size() == 2) begin
      check("gap_iram_w0", iram_log[0], {8'h00, 16'h3518});
      check("gap_iram_w1", iram_log[1], {8'h01, 16'h0001});
    end

    // Asynchronous reset mid data-load, then a fresh frame.
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'hAA, 1'b0);
    check("mid_hd_we_before_reset", {63'b0, hd_we}, 64'd1);
    rstn = 1'b0;
    #1;
    check_all_zero("mid_reset_values");
    @(negedge clk);
    rstn = 1'b1;
    iram_log.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    check("post_reset_iram", {iram_we, iram_waddr, iram_wdata}, {1'b1, 8'h00, 16'h1234});
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_ready("post_reset_back_to_ni");
    check("post_reset_iram_count", iram_log.size(), 1);

    // Watchdog: CPU never returns idle.
    hang = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("wd_start_pulse", {63'b0, cpu_start}, 64'd1);
    n = 0;
    while (!err && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wd_err_set", {63'b0, err}, 64'd1);
    check("wd_err_latency", n, 51);
    s0 = start_cnt;
    h0 = hd_cnt;
    seen_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h05;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_ready || iram_we || hd_we || cpu_start || m_valid) seen_ready = 1'b1;
    end
    s_valid = 1'b0;
    check("wd_halt_quiet", {63'b0, seen_ready}, 64'd0);
    check("wd_no_strobes", {start_cnt - s0, hd_cnt - h0}, 64'd0);
    check("wd_err_sticky", {63'b0, err}, 64'd1);
    hang = 1'b0;
    rstn = 1'b0;
    #1;
    check_all_zero("wd_reset_values");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("wd_ready_after_reset", {63'b0, s_ready}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_host_loader.md
# cpu_host_loader

Host-side controller for the A-RISC `cpu`. It accepts a byte stream carrying a program image and a data image, and writes them into the instruction RAM and data RAM through their host write ports. It then runs the CPU through the `start`/`idle` handshake and streams a window of data RAM back out as bytes. It sits between an external byte link (UART/FIFO) and the CPU subsystem, driving the RAM ports the CPU only reads (IRAM) or shares (DRAM, second port).

## Interface
- `TIMEOUT`, default 0: maximum cycles to wait for `cpu_idle` after start; 0 disables the watchdog.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `s_data`  in  8  inbound byte.
- `s_valid`  in  1  inbound byte valid.
- `s_ready`  out  1  loader accepts byte; transfer when `s_valid && s_ready`.
- `m_data`  out  8  outbound result byte.
- `m_valid`  out  1  outbound byte valid.
- `m_ready`  in  1  sink accepts; transfer when `m_valid && m_ready`.
- `iram_we`  out  1  IRAM write strobe.
- `iram_waddr`  out  8  IRAM write address.
- `iram_wdata`  out  16  instruction word.
- `hd_we`  out  1  DRAM host-port write strobe.
- `hd_addr`  out  8  DRAM host-port address.
- `hd_din`  out  8  DRAM host-port write data.
- `hd_dout`  in  8  DRAM host-port read data, valid 1 cycle after `hd_addr`.
- `cpu_start`  out  1  one-cycle start pulse to the CPU.
- `cpu_idle`  in  1  CPU idle flag.
- `err`  out  1  sticky watchdog error.

## Operation
- Frame, in byte order:
  - `NI`
  - `NI` instruction words, each sent low byte then high byte
  - `ND`
  - `ND` data bytes
  - `NR`
  - `RB`
- Counts are 0..255; a count of 0 skips the corresponding section.
- FSM states: `S_NI`, `S_ILO`, `S_IHI`, `S_ND`, `S_DDAT`, `S_NR`, `S_RB`, `S_START`, `S_RUN`, `S_RD`, `S_WAIT`, `S_SEND`, `S_HALT`.
- `s_ready` = 1 only in `S_NI`, `S_ILO`, `S_IHI`, `S_ND`, `S_DDAT`, `S_NR`, `S_RB`.
- Instruction load: word k = {high, low}, written to IRAM address k, k = 0..NI-1. The low byte carries {rd, opcode}.
- Data load: byte k written to DRAM address k, k = 0..ND-1.
- `S_RB` → `S_START`: `cpu_start` = 1 for exactly one cycle, then → `S_RUN`.
- `S_RUN` → `S_RD` when `cpu_idle` = 1. `cpu_idle` is ignored in the `S_START` cycle.
- Readback, for i = 0..NR-1:
  - `S_RD` drives `hd_addr` = RB+i (8-bit wrap).
  - `S_WAIT` captures `hd_dout` into `m_data`.
  - `S_SEND` holds `m_valid` until `m_ready`.
- After the last byte, or immediately if NR = 0, → `S_NI` for the next frame.
- Watchdog (`TIMEOUT` > 0): counter clears on entry to `S_RUN` and increments each `S_RUN` cycle.
  - On reaching `TIMEOUT`: `err` → 1 and the FSM enters `S_HALT`.
  - `S_HALT` holds all strobes 0 and `s_ready` 0 until `rstn`.
- Address counters are 8 bits; RB+i wraps 255 → 0.
- `hd_we` and `hd_addr` reads never overlap with the CPU run; the DRAM port is used only outside `S_START`/`S_RUN`.

## Timing
- Reset values:
  - `s_ready`, `m_valid`, `m_data`, `iram_we`, `iram_waddr`, `iram_wdata`, `hd_we`, `hd_addr`, `hd_din`, `cpu_start`, `err` all 0.
  - FSM in `S_NI`; `s_ready` = 1 from the first clock after `rstn` rises.
- All outputs are registered.
- `iram_we` pulses 1 cycle, in the cycle after the high-byte handshake; address and data are stable in that cycle.
- `hd_we` pulses 1 cycle after each data-byte handshake.
- Input throughput: 1 byte/cycle with `s_valid` held high.
- Start: `cpu_start` is high in the cycle after the `RB` handshake. The CPU drops `idle` at the next edge.
- Completion latency: `m_valid` rises 3 cycles after `cpu_idle` is sampled high in `S_RUN`.
- Readback rate: 1 byte per 3 cycles maximum.
- Backpressure: while `m_valid && !m_ready`, `m_data` is held stable.
- Reset mid-operation: asserting `rstn` = 0 in any state returns to reset values asynchronously; partial RAM writes are not undone.

## Test plan
- Reset: `rstn` low mid-frame in `S_DDAT` → all outputs 0 immediately; after release `s_ready` = 1 and the next byte is parsed as `NI`.
- IRAM load: bytes 02,18,35,01,00 → `iram_we` pulses with (0, 16'h3518) then (1, 16'h0001); no other writes.
- DRAM load plus empty sections: 00,03,AA,BB,CC,00,00 → `hd_we` pulses at addresses 0,1,2 with AA,BB,CC; exactly one `cpu_start` pulse; no `m_valid`; returns to `S_NI`.
- Readback with wrap and backpressure: DRAM[FE]=11, DRAM[FF]=22, DRAM[00]=33; frame 00,00,03,FE; CPU model idles 10 cycles after start.
  - Required: `m_data` = 11,22,33 in order.
  - With `m_ready` low 5 cycles on byte 2, 22 is held stable.
- Watchdog: `TIMEOUT` = 50, `cpu_idle` held 0 after start → `err` = 1 after 50 `S_RUN` cycles; `s_ready` stays 0 and no strobes until reset.
- Handshake gap: `s_valid` toggled every other cycle across a 2-word program → same IRAM writes as the IRAM load scenario; no byte dropped or duplicated.
